// File: rtl/bomb_scheduler_if.sv
// bomb_scheduler_if: placement handshakes, blast events and tile queries.
// master = game side (players, color_mapper); slave = bomb_scheduler.
interface bomb_scheduler_if #(
  parameter int COORD_W = 4
);
  logic               p1_req;
  logic [COORD_W-1:0] p1_x;
  logic [COORD_W-1:0] p1_y;
  logic               p2_req;
  logic [COORD_W-1:0] p2_x;
  logic [COORD_W-1:0] p2_y;
  logic               p1_grant;
  logic               p1_reject;
  logic               p2_grant;
  logic               p2_reject;
  logic               blast_valid;
  logic [COORD_W-1:0] blast_x;
  logic [COORD_W-1:0] blast_y;
  logic               blast_owner;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               query_bomb;
  logic               query_blast;
  logic [3:0]         active_count;

  modport master (
    output p1_req, p1_x, p1_y,
    output p2_req, p2_x, p2_y,
    output query_x, query_y,
    input  p1_grant, p1_reject,
    input  p2_grant, p2_reject,
    input  blast_valid, blast_x,
    input  blast_y, blast_owner,
    input  query_bomb, query_blast,
    input  active_count
  );

  modport slave (
    input  p1_req, p1_x, p1_y,
    input  p2_req, p2_x, p2_y,
    input  query_x, query_y,
    output p1_grant, p1_reject,
    output p2_grant, p2_reject,
    output blast_valid, blast_x,
    output blast_y, blast_owner,
    output query_bomb, query_blast,
    output active_count
  );
endinterface

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: bomb slots, RR placement arbiter, frame-driven timers.
// Define BOMB_CHAIN_EN to let a blast force nearby fuses to 1 frame.
module bomb_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int COORD_W      = 4,
  parameter int CHAIN_RANGE  = 2
) (
  input logic             Clk,
  input logic             Reset_n,
  input logic             frame_clk,
  bomb_scheduler_if.slave bus
);

  localparam int TMAX = (FUSE_FRAMES > BLAST_FRAMES)
                      ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = $clog2(NUM_SLOTS);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 8 ||
      FUSE_FRAMES < 2 || BLAST_FRAMES < 1 ||
      CHAIN_RANGE < 0) begin : g_bad_cfg
    $error("bomb_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_FREE,
    S_FUSE,
    S_BLAST
  } slot_st_t;

  typedef logic [COORD_W-1:0] crd_t;
  typedef logic [TW-1:0]      tmr_t;
  typedef logic [IW-1:0]      idx_t;

  slot_st_t st_q [NUM_SLOTS];
  slot_st_t st_d [NUM_SLOTS];
  crd_t     x_q  [NUM_SLOTS];
  crd_t     x_d  [NUM_SLOTS];
  crd_t     y_q  [NUM_SLOTS];
  crd_t     y_d  [NUM_SLOTS];
  tmr_t     tm_q [NUM_SLOTS];
  tmr_t     tm_d [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] own_q, own_d;
  logic [NUM_SLOTS-1:0] pend_q, pend_d;
  logic [NUM_SLOTS-1:0] free_v, dup_v;
  logic [NUM_SLOTS-1:0] det_v, pall_v;

  logic [2:0] fs_q;
  logic       tick;
  logic       rr_q;
  logic       p1_el, p2_el;
  logic       sel_p2, svc;
  logic       do_grant, do_rej;
  logic       emit;
  crd_t       rq_x, rq_y;
  idx_t       free_idx, emit_idx;
  logic       qb_d, ql_d;
  logic [3:0] cnt_d;

  logic       g1_q, r1_q, g2_q, r2_q;
  logic       bv_q, bo_q;
  crd_t       bx_q, by_q;
  logic       qb_q, ql_q;
  logic [3:0] cnt_q;

`ifdef BOMB_CHAIN_EN
  function automatic logic near(crd_t a, crd_t b);
    crd_t d;
    d = (a > b) ? a - b : b - a;
    return 32'(d) <= 32'(CHAIN_RANGE);
  endfunction

  function automatic logic in_reach(
    crd_t ax, crd_t ay, crd_t bx, crd_t by
  );
    return (ax == bx && near(ay, by)) ||
           (ay == by && near(ax, bx));
  endfunction
`endif

  // fs_q[1:0] synchronise vs; fs_q[2] is the edge-detect history
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fs_q <= '0;
    else          fs_q <= {fs_q[1:0], frame_clk};
  end

  assign tick = fs_q[1] & ~fs_q[2];

  always_comb begin
    p1_el  = bus.p1_req & ~g1_q & ~r1_q;
    p2_el  = bus.p2_req & ~g2_q & ~r2_q;
    sel_p2 = p2_el & (rr_q | ~p1_el);
    svc    = p1_el | p2_el;
    rq_x   = sel_p2 ? bus.p2_x : bus.p1_x;
    rq_y   = sel_p2 ? bus.p2_y : bus.p1_y;
    free_v   = '0;
    dup_v    = '0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_v[i] = (st_q[i] == S_FREE);
      dup_v[i]  = (st_q[i] != S_FREE) &&
                  (x_q[i] == rq_x) &&
                  (y_q[i] == rq_y);
      if (st_q[i] == S_FREE) free_idx = idx_t'(i);
    end
    do_grant = svc & (|free_v) & ~(|dup_v);
    do_rej   = svc & ~do_grant;
  end

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    tm_d  = tm_q;
    own_d = own_q;
    det_v = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      unique case (1'b1)
        tick && st_q[i] == S_FUSE &&
        tm_q[i] <= tmr_t'(1): begin
          st_d[i]  = S_BLAST;
          tm_d[i]  = tmr_t'(BLAST_FRAMES);
          det_v[i] = 1'b1;
        end
        tick && st_q[i] == S_BLAST &&
        tm_q[i] <= tmr_t'(1): begin
          st_d[i] = S_FREE;
          tm_d[i] = '0;
        end
        tick && st_q[i] != S_FREE &&
        tm_q[i] > tmr_t'(1): begin
          tm_d[i] = tm_q[i] - tmr_t'(1);
        end
        default: ;
      endcase
    end

    // lowest-index pending detonation goes out this cycle
    pall_v   = pend_q | det_v;
    emit     = |pall_v;
    emit_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pall_v[i]) emit_idx = idx_t'(i);
    end
    pend_d = pall_v;
    if (emit) pend_d[emit_idx] = 1'b0;

`ifdef BOMB_CHAIN_EN
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (emit && st_q[i] == S_FUSE && !det_v[i] &&
          in_reach(x_q[i], y_q[i],
                   x_q[emit_idx], y_q[emit_idx])) begin
        tm_d[i] = tmr_t'(1);
      end
    end
`endif

    // grant targets a FREE slot, so the tick above never touches it
    if (do_grant) begin
      st_d[free_idx]  = S_FUSE;
      x_d[free_idx]   = rq_x;
      y_d[free_idx]   = rq_y;
      own_d[free_idx] = sel_p2;
      tm_d[free_idx]  = tmr_t'(FUSE_FRAMES);
    end
  end

  always_comb begin
    qb_d  = 1'b0;
    ql_d  = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (x_q[i] == bus.query_x &&
          y_q[i] == bus.query_y) begin
        qb_d = qb_d | (st_q[i] == S_FUSE);
        ql_d = ql_d | (st_q[i] == S_BLAST);
      end
      if (st_q[i] != S_FREE) cnt_d = cnt_d + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= S_FREE;
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        tm_q[i] <= '0;
      end
      own_q  <= '0;
      pend_q <= '0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tm_q   <= tm_d;
      own_q  <= own_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_q  <= 1'b0;
      g1_q  <= 1'b0;
      r1_q  <= 1'b0;
      g2_q  <= 1'b0;
      r2_q  <= 1'b0;
      bv_q  <= 1'b0;
      bx_q  <= '0;
      by_q  <= '0;
      bo_q  <= 1'b0;
      qb_q  <= 1'b0;
      ql_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (do_grant) rr_q <= ~sel_p2;
      g1_q <= do_grant & ~sel_p2;
      r1_q <= do_rej & ~sel_p2;
      g2_q <= do_grant & sel_p2;
      r2_q <= do_rej & sel_p2;
      bv_q <= emit;
      if (emit) begin
        bx_q <= x_q[emit_idx];
        by_q <= y_q[emit_idx];
        bo_q <= own_q[emit_idx];
      end
      qb_q  <= qb_d;
      ql_q  <= ql_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.p1_grant     = g1_q;
  assign bus.p1_reject    = r1_q;
  assign bus.p2_grant     = g2_q;
  assign bus.p2_reject    = r2_q;
  assign bus.blast_valid  = bv_q;
  assign bus.blast_x      = bx_q;
  assign bus.blast_y      = by_q;
  assign bus.blast_owner  = bo_q;
  assign bus.query_bomb   = qb_q;
  assign bus.query_blast  = ql_q;
  assign bus.active_count = cnt_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: directed vectors for bomb_scheduler.
// Build with +define+BOMB_CHAIN_EN to exercise the chain variant.
module tb_bomb_scheduler;
  localparam int CW = 4;

  logic Clk       = 1'b0;
  logic Reset_n   = 1'b0;
  logic frame_clk = 1'b0;
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   blast_cnt = 0;
  int   b0;

  bomb_scheduler_if #(.COORD_W(CW)) bus ();

  bomb_scheduler #(
    .NUM_SLOTS   (4),
    .FUSE_FRAMES (120),
    .BLAST_FRAMES(30),
    .COORD_W     (CW),
    .CHAIN_RANGE (2)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .bus      (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (bus.blast_valid) blast_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  // returns at the negedge where post-tick outputs are visible
  task automatic frame();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic place(input bit who, input int x,
                       input int y, input bit ok,
                       input string tag);
    if (!who) begin
      bus.p1_req = 1'b1;
      bus.p1_x   = CW'(x);
      bus.p1_y   = CW'(y);
    end else begin
      bus.p2_req = 1'b1;
      bus.p2_x   = CW'(x);
      bus.p2_y   = CW'(y);
    end
    step();
    check({tag, "_grant"},
          who ? bus.p2_grant : bus.p1_grant, ok);
    check({tag, "_reject"},
          who ? bus.p2_reject : bus.p1_reject, !ok);
    bus.p1_req = 1'b0;
    bus.p2_req = 1'b0;
    step();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    step(2);
    Reset_n = 1'b1;
    step();
  endtask

  task automatic chk_blast(input string tag, input int x,
                           input int y, input int o);
    check({tag, "_v"}, bus.blast_valid, 1);
    check({tag, "_x"}, bus.blast_x, x);
    check({tag, "_y"}, bus.blast_y, y);
    check({tag, "_o"}, bus.blast_owner, o);
  endtask

  int ex [3] = '{0, 7, 12};
  int ey [3] = '{0, 9, 14};
  int eo [3] = '{0, 1, 0};

  initial begin
    bus.p1_req  = 1'b0;
    bus.p1_x    = '0;
    bus.p1_y    = '0;
    bus.p2_req  = 1'b0;
    bus.p2_x    = '0;
    bus.p2_y    = '0;
    bus.query_x = CW'(3);
    bus.query_y = CW'(5);
    step(2);
    Reset_n = 1'b1;
    step();

    check("rst_cnt", bus.active_count, 0);
    check("rst_bv", bus.blast_valid, 0);
    check("rst_qb", bus.query_bomb, 0);
    check("rst_pulses", {bus.p1_grant, bus.p1_reject,
                         bus.p2_grant, bus.p2_reject}, 0);

    // single bomb lifecycle
    place(0, 3, 5, 1, "s1");
    check("s1_qbomb", bus.query_bomb, 1);
    check("s1_cnt", bus.active_count, 1);
    b0 = blast_cnt;
    frames(119);
    step();
    check("s1_early", blast_cnt - b0, 0);
    frame();
    chk_blast("s1_blast", 3, 5, 0);
    step();
    check("s1_pulse", bus.blast_valid, 0);
    check("s1_hold_x", bus.blast_x, 3);
    check("s1_qblast", bus.query_blast, 1);
    check("s1_qbomb0", bus.query_bomb, 0);
    frames(29);
    step();
    check("s1_cnt_blast", bus.active_count, 1);
    frame();
    step();
    check("s1_cnt_free", bus.active_count, 0);
    check("s1_qblast0", bus.query_blast, 0);

    // full table, slot 0 reuse
    do_reset();
    place(0, 1, 1, 1, "f0");
    frames(60);
    place(1, 6, 3, 1, "f1");
    place(0, 9, 7, 1, "f2");
    place(1, 13, 11, 1, "f3");
    check("f_cnt4", bus.active_count, 4);
    place(1, 5, 12, 0, "f_full");
    check("f_cnt4b", bus.active_count, 4);
    frames(59);
    frame();
    chk_blast("f_b0", 1, 1, 0);
    frames(29);
    place(1, 10, 10, 0, "f_still");
    frame();
    place(0, 10, 10, 1, "f_reuse");
    check("f_cnt_re", bus.active_count, 4);

    // same-tile contention
    do_reset();
    bus.p1_x = CW'(2); bus.p1_y = CW'(2);
    bus.p2_x = CW'(2); bus.p2_y = CW'(2);
    bus.p1_req = 1'b1;
    bus.p2_req = 1'b1;
    step();
    check("c1_g1", bus.p1_grant, 1);
    check("c1_p2", {bus.p2_grant, bus.p2_reject}, 0);
    bus.p1_req = 1'b0;
    step();
    check("c1_r2", bus.p2_reject, 1);
    check("c1_g2", bus.p2_grant, 0);
    bus.p2_req = 1'b0;
    step();
    bus.p1_x = CW'(6); bus.p1_y = CW'(6);
    bus.p2_x = CW'(6); bus.p2_y = CW'(6);
    bus.p1_req = 1'b1;
    bus.p2_req = 1'b1;
    step();
    check("c2_g2", bus.p2_grant, 1);
    check("c2_p1", {bus.p1_grant, bus.p1_reject}, 0);
    bus.p2_req = 1'b0;
    step();
    check("c2_r1", bus.p1_reject, 1);
    bus.p1_req = 1'b0;
    step();

    // three bombs detonating on one tick
    do_reset();
    for (int i = 0; i < 3; i++)
      place(eo[i] != 0, ex[i], ey[i], 1, "m");
    frames(119);
    frame();
    for (int i = 0; i < 3; i++) begin
      chk_blast($sformatf("m_b%0d", i), ex[i], ey[i], eo[i]);
      step();
    end
    check("m_end", bus.blast_valid, 0);

    // reset mid-fuse
    do_reset();
    bus.query_x = CW'(5);
    bus.query_y = CW'(5);
    place(0, 5, 5, 1, "r");
    frames(10);
    check("r_qb", bus.query_bomb, 1);
    Reset_n = 1'b0;
    #1;
    check("r_cnt", bus.active_count, 0);
    check("r_qb0", bus.query_bomb, 0);
    check("r_bv", bus.blast_valid, 0);
    step(2);
    Reset_n = 1'b1;
    b0 = blast_cnt;
    frames(130);
    step();
    check("r_noblast", blast_cnt - b0, 0);
    check("r_cnt2", bus.active_count, 0);

    // chain reaction (or its absence)
    do_reset();
    place(0, 4, 4, 1, "k0");
    frames(60);
    place(1, 4, 6, 1, "k1");
    frames(59);
    frame();
    chk_blast("k_b0", 4, 4, 0);
    frame();
`ifdef BOMB_CHAIN_EN
    chk_blast("k_chain", 4, 6, 1);
`else
    check("k_nochain", bus.blast_valid, 0);
    frames(58);
    frame();
    chk_blast("k_own", 4, 6, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
